// File: rtl/fpu_issue_seq_if.sv
// Request/response handshake bundle between the execute stage and the FPU issue sequencer.
// The execute stage is the master; the sequencer is the slave.
interface fpu_issue_seq_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [DATA_W-1:0] req_rs1;
    logic [DATA_W-1:0] req_rs2;
    logic [4:0]        req_rd;
    logic [2:0]        req_rm;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_rd;
    logic [4:0]        resp_flags;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, req_rm, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_flags
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_rm, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_flags
    );
endinterface

// File: rtl/fpu_issue_seq.sv
// Single-outstanding FPU request sequencer: holds FPU inputs for a fixed per-op
// latency, captures result and flags, and owns the fcsr (frm + sticky fflags).
module fpu_issue_seq #(
    parameter int DATA_W   = 32,
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 12,
    parameter int LAT_CVT  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    fpu_issue_seq_if.slave    bus,
    output logic [5:0]        fpu_operation,
    output logic [DATA_W-1:0] fpu_rs1,
    output logic [DATA_W-1:0] fpu_rs2,
    output logic [31:0]       fpu_fcsr,
    input  logic [DATA_W-1:0] fpu_result,
    input  logic [4:0]        fpu_flags,
    input  logic              csr_we,
    input  logic [7:0]        csr_wdata,
    output logic [31:0]       fcsr
);
    localparam int LAT_M0  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_M1  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
    localparam int LAT_M2  = (LAT_M0 > LAT_M1) ? LAT_M0 : LAT_M1;
    localparam int LAT_MAX = (LAT_M2 > LAT_CVT) ? LAT_M2 : LAT_CVT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [4:0]       FLAG_NV = 5'b10000;
    localparam logic [2:0]       RM_DYN  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [5:0]        op_q;
    logic [DATA_W-1:0] rs1_q;
    logic [DATA_W-1:0] rs2_q;
    logic [4:0]        rd_q;
    logic [2:0]        eff_rm_q;
    logic [2:0]        frm_q;
    logic [4:0]        fflags_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [4:0]        resp_rd_q;
    logic [4:0]        resp_flags_q;

    logic       accept;
    logic       illegal;
    logic       capture;
    logic [2:0] eff_rm;

    function automatic logic [CNT_W-1:0] lat_for(input logic [5:0] op);
        logic [CNT_W-1:0] lat;
        case (op)
            6'd0:    lat = CNT_W'(LAT_ADD);
            6'd1:    lat = CNT_W'(LAT_MUL);
            6'd2:    lat = CNT_W'(LAT_DIV);
            6'd3:    lat = CNT_W'(LAT_SQRT);
            default: lat = CNT_W'(LAT_CVT);
        endcase
        return lat;
    endfunction

    // Opcodes above 7 and the reserved rounding modes 5..7 never reach the FPU.
    function automatic logic req_illegal(input logic [5:0] op, input logic [2:0] rm);
        return (op > 6'd7) || (rm >= 3'd5);
    endfunction

    function automatic logic [2:0] resolve_rm(input logic [2:0] req_rm, input logic [2:0] frm);
        return (req_rm == RM_DYN) ? frm : req_rm;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        illegal        = 1'b0;
        capture        = 1'b0;
        eff_rm         = resolve_rm(bus.req_rm, frm_q);
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_illegal(bus.req_op, eff_rm)) begin
                        illegal = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // A counter at or below one means the FPU output is valid this cycle.
                if (cnt_q <= CNT_ONE) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue stage: operands and resolved rounding mode are frozen for the whole op.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= '0;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            eff_rm_q <= '0;
        end else if (accept && !illegal) begin
            cnt_q    <= lat_for(bus.req_op);
            op_q     <= bus.req_op;
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            rd_q     <= bus.req_rd;
            eff_rm_q <= eff_rm;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Response stage: only written on the transition into RESP, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_flags_q <= '0;
        end else if (capture) begin
            resp_data_q  <= fpu_result;
            resp_rd_q    <= rd_q;
            resp_flags_q <= fpu_flags;
        end else if (accept && illegal) begin
            resp_data_q  <= '0;
            resp_rd_q    <= bus.req_rd;
            resp_flags_q <= FLAG_NV;
        end
    end

    // A software CSR write overrides the same-cycle sticky-flag accumulation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frm_q    <= '0;
            fflags_q <= '0;
        end else if (csr_we) begin
            frm_q    <= csr_wdata[7:5];
            fflags_q <= csr_wdata[4:0];
        end else if (capture) begin
            fflags_q <= fflags_q | fpu_flags;
        end else if (accept && illegal) begin
            fflags_q <= fflags_q | FLAG_NV;
        end
    end

    assign fpu_operation  = op_q;
    assign fpu_rs1        = rs1_q;
    assign fpu_rs2        = rs2_q;
    assign fpu_fcsr       = {24'b0, eff_rm_q, fflags_q};
    assign fcsr           = {24'b0, frm_q, fflags_q};
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_flags = resp_flags_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Self-checking bench for fpu_issue_seq: directed scenarios followed by random traffic,
// compared every cycle against a timestamp-based transaction model.
module tb_fpu_issue_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_seq_if bus ();

    logic [5:0]  fpu_operation;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic [31:0] fpu_fcsr;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        csr_we;
    logic [7:0]  csr_wdata;
    logic [31:0] fcsr;

    fpu_issue_seq dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus.slave),
        .fpu_operation (fpu_operation),
        .fpu_rs1       (fpu_rs1),
        .fpu_rs2       (fpu_rs2),
        .fpu_fcsr      (fpu_fcsr),
        .fpu_result    (fpu_result),
        .fpu_flags     (fpu_flags),
        .csr_we        (csr_we),
        .csr_wdata     (csr_wdata),
        .fcsr          (fcsr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Stimulus for the current cycle, plus the result the stub FPU returns for the next accepted op.
    logic [31:0] nxt_res;
    logic [4:0]  nxt_flg;

    // Transaction-level reference state.
    bit          m_known = 0;
    bit          m_pending = 0;
    bit          m_illegal = 0;
    bit          m_accepted = 0;
    int          m_sample_cyc = -1;
    int          m_resp_cyc = -1;
    logic [5:0]  m_op;
    logic [31:0] m_rs1, m_rs2, m_res;
    logic [4:0]  m_rd, m_flg;
    logic [2:0]  m_eff, m_frm;
    logic [4:0]  m_fflags;
    logic [31:0] m_resp_data;
    logic [4:0]  m_resp_rd, m_resp_flags;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'd0:    return 2;
            6'd1:    return 3;
            6'd2:    return 12;
            6'd3:    return 12;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_pending = 0; m_illegal = 0; m_sample_cyc = -1; m_resp_cyc = -1;
        m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_eff = '0;
        m_res = '0; m_flg = '0; m_frm = '0; m_fflags = '0;
        m_resp_data = '0; m_resp_rd = '0; m_resp_flags = '0;
    endtask

    // Advance the model across the clock edge that ends cycle `cyc`.
    task automatic model_edge();
        bit         do_acc;
        logic [4:0] acc_flags;
        logic [2:0] eff;
        m_accepted = 0;
        do_acc = 0;
        acc_flags = '0;
        if (!resetn) begin
            model_reset();
            m_known = 1;
            return;
        end
        if (m_pending && !m_illegal && cyc == m_sample_cyc) begin
            m_resp_data = m_res; m_resp_flags = m_flg; m_resp_rd = m_rd;
            do_acc = 1; acc_flags = m_flg;
        end
        if (m_pending && cyc >= m_resp_cyc && bus.resp_ready) begin
            m_pending = 0;
        end else if (!m_pending && bus.req_valid) begin
            m_accepted = 1;
            m_pending = 1;
            eff = (bus.req_rm == 3'd7) ? m_frm : bus.req_rm;
            if (bus.req_op > 6'd7 || eff >= 3'd5) begin
                m_illegal = 1;
                m_resp_cyc = cyc + 1;
                m_resp_data = '0; m_resp_flags = 5'h10; m_resp_rd = bus.req_rd;
                do_acc = 1; acc_flags = 5'h10;
            end else begin
                m_illegal = 0;
                m_sample_cyc = cyc + lat_of(bus.req_op);
                m_resp_cyc = m_sample_cyc + 1;
                m_op = bus.req_op; m_rs1 = bus.req_rs1; m_rs2 = bus.req_rs2;
                m_rd = bus.req_rd; m_eff = eff; m_res = nxt_res; m_flg = nxt_flg;
            end
        end
        if (csr_we) {m_frm, m_fflags} = csr_wdata;
        else if (do_acc) m_fflags = m_fflags | acc_flags;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = m_pending && (cyc >= m_resp_cyc);
        chk("req_ready", 32'(bus.req_ready), 32'(!m_pending));
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
        chk("fpu_operation", 32'(fpu_operation), 32'(m_op));
        chk("fpu_rs1", fpu_rs1, m_rs1);
        chk("fpu_rs2", fpu_rs2, m_rs2);
        chk("fpu_fcsr", fpu_fcsr, {24'b0, m_eff, m_fflags});
        chk("fcsr", fcsr, {24'b0, m_frm, m_fflags});
        chk("resp_data", bus.resp_data, m_resp_data);
        chk("resp_rd", 32'(bus.resp_rd), 32'(m_resp_rd));
        chk("resp_flags", 32'(bus.resp_flags), 32'(m_resp_flags));
    endtask

    // One clock cycle: drive the stub FPU, check mid-cycle, update the model at the edge.
    task automatic run_cycle();
        if (m_pending && !m_illegal && cyc == m_sample_cyc) begin
            fpu_result = m_res;
            fpu_flags  = m_flg;
        end else begin
            fpu_result = $urandom;
            fpu_flags  = 5'($urandom);
        end
        @(negedge clk);
        if (m_known) check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic csr_write(input logic [7:0] w);
        csr_we = 1'b1;
        csr_wdata = w;
        run_cycle();
        csr_we = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [2:0] rm,
                         input logic [31:0] res, input logic [4:0] flg);
        bit done;
        done = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b;
        bus.req_rd = rd; bus.req_rm = rm; nxt_res = res; nxt_flg = flg;
        for (int k = 0; k < 64 && !done; k++) begin
            run_cycle();
            done = m_accepted;
        end
        bus.req_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input int hold);
        bus.resp_ready = 1'b0;
        idle(hold);
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 64 && m_pending; k++) run_cycle();
        bus.resp_ready = 1'b0;
        if (m_pending) chk("drain_timeout", 32'(m_pending), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_rd = '0; bus.req_rm = '0; bus.resp_ready = 1'b0;
        csr_we = 1'b0; csr_wdata = '0; nxt_res = '0; nxt_flg = '0;
        fpu_result = '0; fpu_flags = '0;
        @(posedge clk);
        #1;

        // Reset state
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(2);

        // fcvt.s.w of 5, then fadd 1.0 + 2.0
        issue(6'd4, 32'd5, 32'd0, 5'd3, 3'd0, 32'h40A00000, 5'h00);
        drain(0);
        issue(6'd0, 32'h3F800000, 32'h40000000, 5'd7, 3'd0, 32'h40400000, 5'h00);
        drain(2);

        // Dynamic rounding resolved at accept; frm write in flight does not disturb it
        csr_write(8'b100_00000);
        issue(6'd6, 32'h3F800000, 32'd0, 5'd9, 3'd7, 32'd1, 5'h01);
        csr_write(8'b001_00000);
        drain(1);
        issue(6'd1, 32'h40000000, 32'h40400000, 5'd10, 3'd7, 32'h40C00000, 5'h01);
        csr_write(8'b011_00000);
        drain(0);

        // Illegal opcode and reserved dynamic rounding mode
        issue(6'd9, 32'h1234, 32'h5678, 5'd11, 3'd0, 32'hDEADBEEF, 5'h00);
        drain(0);
        csr_write(8'b101_00000);
        issue(6'd0, 32'h1, 32'h2, 5'd12, 3'd7, 32'hDEADBEEF, 5'h00);
        drain(3);
        issue(6'd4, 32'h1, 32'h0, 5'd13, 3'd6, 32'hDEADBEEF, 5'h00);
        drain(0);

        // fdiv with a stalled consumer, then fdiv with a CSR clear on the RESP-entry edge
        csr_write(8'h00);
        issue(6'd2, 32'h40800000, 32'h40000000, 5'd14, 3'd1, 32'h40000000, 5'h08);
        drain(5);
        csr_write(8'h00);
        issue(6'd2, 32'h40800000, 32'h40000000, 5'd15, 3'd2, 32'h40000000, 5'h08);
        for (int k = 0; k < 64 && cyc != m_sample_cyc; k++) run_cycle();
        csr_write(8'h00);
        drain(2);

        // Reset in the middle of an fdiv abandons it
        issue(6'd2, 32'h3F800000, 32'h40400000, 5'd16, 3'd0, 32'h3EAAAAAB, 5'h01);
        idle(4);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        bus.resp_ready = 1'b1;
        idle(20);
        bus.resp_ready = 1'b0;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 399) != 0);
            bus.req_valid = ($urandom_range(0, 1) == 1);
            bus.req_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            bus.req_rs1 = $urandom;
            bus.req_rs2 = $urandom;
            bus.req_rd = 5'($urandom);
            bus.req_rm = 3'($urandom);
            bus.resp_ready = ($urandom_range(0, 4) < 3);
            csr_we = ($urandom_range(0, 19) == 0);
            csr_wdata = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {3'($urandom_range(0, 4)), 5'($urandom)};
            nxt_res = $urandom;
            nxt_flg = 5'($urandom);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
Core-side initiator for the floating-point unit. It accepts one FP request at a time from the execute stage over a valid/ready handshake and drives the FPU's operation, rs1, rs2 and fcsr inputs. It holds those inputs stable for the operation's fixed latency, then captures the FPU result and exception flags. It owns the fcsr register (frm and fflags), accumulates the sticky flags, and returns the result with its destination register over a valid/ready response handshake.

Parameters:
LAT_ADD, 2, cycles FPU inputs held before sampling for op 0 (fadd)
LAT_MUL, 3, same, op 1 (fmul)
LAT_DIV, 12, same, op 2 (fdiv)
LAT_SQRT, 12, same, op 3 (fsqrt)
LAT_CVT, 1, same, ops 4-7 (fcvt.s.w, fcvt.s.wu, fcvt.w.s, fcvt.wu.s)

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  6  operation code; 0-7 legal
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
req_rd  in  5  destination register tag
req_rm  in  3  instruction rounding mode; 7 = dynamic
fpu_operation  out  6  to FPU operation
fpu_rs1  out  32  to FPU rs1
fpu_rs2  out  32  to FPU rs2
fpu_fcsr  out  32  to FPU fcsr: {24'b0, eff_rm, fflags}
fpu_result  in  32  FPU result
fpu_flags  in  5  FPU exception flags {NV,DZ,OF,UF,NX}, valid with fpu_result
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  32  result
resp_rd  out  5  destination tag
resp_flags  out  5  flags raised by this op
csr_we  in  1  fcsr write strobe
csr_wdata  in  8  new {frm, fflags}
fcsr  out  32  {24'b0, frm, fflags}

Behaviour:
- Reset:
  - state=IDLE; req_ready=1; resp_valid=0.
  - All fpu_* outputs, resp_data, resp_rd, resp_flags and fcsr are 0.
  - Reset mid-operation abandons the op; no response is produced.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1, high only in IDLE.
  - On req_valid&&req_ready: latch op, rs1, rs2, rd.
  - eff_rm = (req_rm==7) ? frm : req_rm, latched at accept.
  - Load cnt with the latency for the op; go BUSY.
- Illegal accept, taken in the accept cycle without entering BUSY:
  - Triggered by op>7, or by an eff_rm value of 5, 6 or 7.
  - Go directly to RESP with resp_data=0 and resp_flags=5'b10000 (NV).
  - FPU outputs are not updated.
- BUSY:
  - fpu_operation/rs1/rs2/fcsr are driven from the latched values, stable every BUSY cycle.
  - cnt decrements each cycle.
  - In the cycle cnt==1: register fpu_result to resp_data, fpu_flags to resp_flags, rd to resp_rd; go RESP.
  - Request accepted at cycle T means resp_valid is first high at T+1+LAT.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - On resp_valid&&resp_ready go IDLE. Next accept is possible the following cycle, with no back-to-back accept in the handshake cycle.
- fflags accumulation: fflags |= resp_flags exactly once, on the cycle RESP is entered. Illegal requests also OR in NV.
- CSR write:
  - csr_we in any state: {frm, fflags} <= csr_wdata.
  - If it coincides with flag accumulation, the CSR write wins; captured flags are dropped from fcsr but still appear on resp_flags.
  - A frm change during BUSY does not affect the in-flight op, because eff_rm is already latched.
- fpu_fcsr bits[4:0] carry the current fflags; bits[7:5] carry eff_rm.

Test Plan:
- Op 4, rs1=32'd5, rm=0, accept at T -> fpu_operation=4 from T+1; resp_valid at T+2; resp_data=32'h40A00000; resp_rd echoes; flags 0.
- Op 0, rs1=32'h3F800000, rs2=32'h40000000 -> resp_valid at T+3; resp_data=32'h40400000; req_ready=0 during T+1..response handshake.
- csr_wdata=8'b100_00000, then op 6 with rm=7 -> fpu_fcsr[7:5]=3'b100 throughout BUSY; a csr write of frm=1 during BUSY leaves fpu_fcsr unchanged.
- Op 9 -> resp_valid next cycle; resp_data=0; resp_flags=5'h10; fcsr[4]=1. Also rm=7 with frm=5 gives the same NV response.
- Op 2, stub FPU flags=5'h08, resp_ready low 5 cycles -> resp_* stable all 5 cycles; fcsr[3] set once; csr_we with 8'h00 on the RESP-entry cycle leaves fflags=0.
- resetn low at T+5 during op 2 -> next cycle state IDLE, req_ready=1, resp_valid=0, fcsr=0; no response is ever issued.
